huffman_dc_decoder: RTL and testbench
=====================================

Name: huffman_dc_decoder

Overview:
- Receive-side counterpart of the encoder's packed bitstream output (`jpeg_out`/`jpeg_data_bits`).
- Accepts variable-width bit chunks (0..8 valid bits per beat) and buffers them in a 32-bit bit queue.
- Decodes one JPEG baseline DC symbol (Annex K Huffman category code plus magnitude bits) and emits the signed DC difference on a valid/ready output.
- First stage of the team's JPEG decode path; feeds the future AC decoder/dezigzag.

Parameters:
- BUF_BITS, 32, bit-queue depth in bits (must be ≥ 30).
- OUT_WIDTH, 12, width of signed dc_value.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  chunk present
- in_ready  out  1  chunk accepted when in_valid & in_ready
- jpeg_in  in  8  chunk data; valid bits are jpeg_in[jpeg_data_bits-1:0]; first-transmitted bit is jpeg_in[jpeg_data_bits-1]
- jpeg_data_bits  in  4  number of valid bits, 0..8
- is_luminance  in  1  1 = luminance DC table, 0 = chrominance DC table
- dc_valid  out  1  decoded symbol available
- dc_ready  in  1  consumer accepts symbol
- dc_size  out  4  decoded category 0..11
- dc_value  out  OUT_WIDTH  signed two's-complement DC difference
- err  out  1  sticky decode/protocol error

Behaviour:
- Clock/reset: one clock; reset is synchronous, active-low (reset_n sampled on the rising edge of clock). Reset clears the queue, count, FSM (→ CODE), and all outputs: dc_valid=0, dc_size=0, dc_value=0, err=0. Reset mid-symbol discards all partial data.
- Queue: bits held MSB-aligned; `count` = 0..BUF_BITS.
  - in_ready = (count ≤ BUF_BITS-8) && state≠ERR, using registered count.
  - On accept, the chunk is appended behind existing bits.
  - Same-cycle append and consume: count_next = count + appended − consumed. The consumed bits are taken from the old head.
  - jpeg_data_bits=0 is an accepted no-op.
  - jpeg_data_bits>8 with in_valid: beat is accepted and discarded, err←1, FSM→ERR.
- FSM states: CODE, MAG, OUT, ERR.
  - CODE: is_luminance is sampled when entering CODE and held for the symbol. The queue head is compared against the table codes.
    - When head bits match a code of length L and count ≥ L: consume L bits, latch size, go to MAG.
    - If count ≥ max code length (lum 9, chroma 11) and nothing matches: err←1, go to ERR.
    - Otherwise wait.
  - Luminance codes, cat 0..11: 00, 010, 011, 100, 101, 110, 1110, 11110, 111110, 1111110, 11111110, 111111110.
  - Chrominance codes, cat 0..11: 00, 01, 10, 110, 1110, 11110, 111110, 1111110, 11111110, 111111110, 1111111110, 11111111110.
  - MAG:
    - size=0: value=0, consume nothing, go to OUT next cycle.
    - Else wait for count ≥ size, then consume size bits as mag.
    - If mag MSB=1: value = +mag. If mag MSB=0: value = mag − (2^size − 1). Sign-extend to OUT_WIDTH.
    - Register dc_size/dc_value, go to OUT.
  - OUT: dc_valid=1; dc_size and dc_value are held stable until dc_valid & dc_ready. On handshake: dc_valid←0, go to CODE. The queue keeps accepting input while in OUT.
  - ERR: in_ready=0, dc_valid=0; only reset exits.
- Latency: with the full symbol already queued, dc_valid rises 2 clocks after CODE is entered. Throughput is one symbol per 3 clocks maximum.

Optional Feature:
- Macro: DC_PREDICTOR_EN.
- Defined:
  - A 12-bit signed predictor register, reset to 0.
  - dc_value outputs pred + diff (wrapping at OUT_WIDTH).
  - pred is updated to the output value on each dc handshake.
  - A single predictor is shared by both tables; the caller sequences components.
- Undefined: dc_value is the raw difference; no predictor register.

Test Plan:
- Lum, single beat jpeg_in=8'b0010_0101 with bits=6 (stream 100101) → dc_size=3, dc_value=+5; dc_valid 2 cycles after CODE entry.
- Lum, stream 01101 sent as 3 beats of 2,2,1 bits → dc_size=2, dc_value=−2.
- Chroma, stream 00 → dc_size=0, dc_value=0. Then immediately chroma 11111111110 followed by 11 ones → dc_size=11, dc_value=+2047.
- Lum, 111111110 followed by 00000000000 → dc_size=11, dc_value=−2047.
- Backpressure: dc_ready=0 for 10 cycles while beats of 8 bits keep arriving → in_ready drops at count>24; dc_value stable; no bit lost; the next symbol decodes correctly after release.
- Chroma, 11 ones → err=1, in_ready=0 held. Then reset_n=0 for 1 cycle → all outputs 0 and in_ready=1.
- With DC_PREDICTOR_EN: diffs +5, −2 → dc_value 5, then 3.

Source files
------------

// File: rtl/huffman_dc_decoder.sv
// JPEG baseline DC symbol decoder: buffers 0..8-bit chunks in an MSB-aligned bit queue.
// Optional macro DC_PREDICTOR_EN adds a running predictor so dc_value carries pred + diff.
module huffman_dc_decoder #(
    parameter int BUF_BITS  = 32,
    parameter int OUT_WIDTH = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           jpeg_in,
    input  logic [3:0]           jpeg_data_bits,
    input  logic                 is_luminance,
    output logic                 dc_valid,
    input  logic                 dc_ready,
    output logic [3:0]           dc_size,
    output logic [OUT_WIDTH-1:0] dc_value,
    output logic                 err
);
    localparam int CW = $clog2(BUF_BITS + 1);
    localparam logic [OUT_WIDTH-1:0] ONE = {{(OUT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {CODE, MAG, OUT, ERR} state_t;

    state_t                state_q, state_d;
    logic [BUF_BITS-1:0]   buf_q, buf_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  lum_q, lum_d;
    logic                  first_q, first_d;
    logic [3:0]            size_q, size_d;
    logic                  dc_valid_q, dc_valid_d;
    logic [3:0]            dc_size_q, dc_size_d;
    logic [OUT_WIDTH-1:0]  dc_value_q, dc_value_d;
    logic                  err_q, err_d;
`ifdef DC_PREDICTOR_EN
    logic [OUT_WIDTH-1:0]  pred_q, pred_d;
`endif

    logic [10:0]           head;
    logic                  lum_eff;
    logic                  hit;
    logic [3:0]            code_len, code_size;
    logic [10:0]           mag;
    logic [OUT_WIDTH-1:0]  mag_ext, diff;
    logic                  accept, bad_beat;
    logic [3:0]            consume, app_n;
    logic [CW-1:0]         cnt_after;

    assign head     = buf_q[BUF_BITS-1 -: 11];
    // Table select is taken live on the first CODE cycle of a symbol, then held.
    assign lum_eff  = first_q ? is_luminance : lum_q;
    assign in_ready = (count_q <= CW'(BUF_BITS - 8)) && (state_q != ERR);
    assign accept   = in_valid && in_ready;
    assign bad_beat = accept && (jpeg_data_bits > 4'd8);

    always_comb begin
        {hit, code_len, code_size} = '0;
        if (lum_eff) begin
            casez (head)
                11'b00?????????: {hit, code_len, code_size} = {1'b1, 4'd2, 4'd0};
                11'b010????????: {hit, code_len, code_size} = {1'b1, 4'd3, 4'd1};
                11'b011????????: {hit, code_len, code_size} = {1'b1, 4'd3, 4'd2};
                11'b100????????: {hit, code_len, code_size} = {1'b1, 4'd3, 4'd3};
                11'b101????????: {hit, code_len, code_size} = {1'b1, 4'd3, 4'd4};
                11'b110????????: {hit, code_len, code_size} = {1'b1, 4'd3, 4'd5};
                11'b1110???????: {hit, code_len, code_size} = {1'b1, 4'd4, 4'd6};
                11'b11110??????: {hit, code_len, code_size} = {1'b1, 4'd5, 4'd7};
                11'b111110?????: {hit, code_len, code_size} = {1'b1, 4'd6, 4'd8};
                11'b1111110????: {hit, code_len, code_size} = {1'b1, 4'd7, 4'd9};
                11'b11111110???: {hit, code_len, code_size} = {1'b1, 4'd8, 4'd10};
                11'b111111110??: {hit, code_len, code_size} = {1'b1, 4'd9, 4'd11};
                default:         {hit, code_len, code_size} = '0;
            endcase
        end else begin
            casez (head)
                11'b00?????????: {hit, code_len, code_size} = {1'b1, 4'd2, 4'd0};
                11'b01?????????: {hit, code_len, code_size} = {1'b1, 4'd2, 4'd1};
                11'b10?????????: {hit, code_len, code_size} = {1'b1, 4'd2, 4'd2};
                11'b110????????: {hit, code_len, code_size} = {1'b1, 4'd3, 4'd3};
                11'b1110???????: {hit, code_len, code_size} = {1'b1, 4'd4, 4'd4};
                11'b11110??????: {hit, code_len, code_size} = {1'b1, 4'd5, 4'd5};
                11'b111110?????: {hit, code_len, code_size} = {1'b1, 4'd6, 4'd6};
                11'b1111110????: {hit, code_len, code_size} = {1'b1, 4'd7, 4'd7};
                11'b11111110???: {hit, code_len, code_size} = {1'b1, 4'd8, 4'd8};
                11'b111111110??: {hit, code_len, code_size} = {1'b1, 4'd9, 4'd9};
                11'b1111111110?: {hit, code_len, code_size} = {1'b1, 4'd10, 4'd10};
                11'b11111111110: {hit, code_len, code_size} = {1'b1, 4'd11, 4'd11};
                default:         {hit, code_len, code_size} = '0;
            endcase
        end
    end

    // size 0 yields mag 0 and diff 0 for either head MSB, so no special case is needed.
    assign mag     = head >> (4'd11 - size_q);
    assign mag_ext = OUT_WIDTH'(mag);
    assign diff    = head[10] ? mag_ext : mag_ext - ((ONE << size_q) - ONE);

    always_comb begin
        state_d    = state_q;
        lum_d      = lum_q;
        first_d    = first_q;
        size_d     = size_q;
        dc_valid_d = dc_valid_q;
        dc_size_d  = dc_size_q;
        dc_value_d = dc_value_q;
        err_d      = err_q;
        consume    = '0;
`ifdef DC_PREDICTOR_EN
        pred_d     = pred_q;
`endif
        case (state_q)
            CODE: begin
                lum_d   = lum_eff;
                first_d = 1'b0;
                if (hit && (count_q >= CW'(code_len))) begin
                    consume = code_len;
                    size_d  = code_size;
                    state_d = MAG;
                end else if (count_q >= CW'(lum_eff ? 4'd9 : 4'd11)) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            MAG: begin
                if (count_q >= CW'(size_q)) begin
                    consume    = size_q;
                    dc_size_d  = size_q;
`ifdef DC_PREDICTOR_EN
                    dc_value_d = pred_q + diff;
`else
                    dc_value_d = diff;
`endif
                    dc_valid_d = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (dc_ready) begin
                    dc_valid_d = 1'b0;
                    first_d    = 1'b1;
                    state_d    = CODE;
`ifdef DC_PREDICTOR_EN
                    pred_d     = dc_value_q;
`endif
                end
            end
            default: ;
        endcase
        if (bad_beat) begin
            err_d      = 1'b1;
            dc_valid_d = 1'b0;
            state_d    = ERR;
        end
    end

    // Consumption comes off the old head; the new chunk lands right behind what remains.
    always_comb begin
        app_n     = (accept && !bad_beat) ? jpeg_data_bits : 4'd0;
        cnt_after = count_q - CW'(consume);
        buf_d     = (buf_q << consume)
                  | (({jpeg_in, {(BUF_BITS-8){1'b0}}} << (4'd8 - app_n)) >> cnt_after);
        count_d   = cnt_after + CW'(app_n);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= CODE;
            buf_q      <= '0;
            count_q    <= '0;
            lum_q      <= 1'b0;
            first_q    <= 1'b1;
            size_q     <= '0;
            dc_valid_q <= 1'b0;
            dc_size_q  <= '0;
            dc_value_q <= '0;
            err_q      <= 1'b0;
`ifdef DC_PREDICTOR_EN
            pred_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            lum_q      <= lum_d;
            first_q    <= first_d;
            size_q     <= size_d;
            dc_valid_q <= dc_valid_d;
            dc_size_q  <= dc_size_d;
            dc_value_q <= dc_value_d;
            err_q      <= err_d;
`ifdef DC_PREDICTOR_EN
            pred_q     <= pred_d;
`endif
        end
    end

    assign dc_valid = dc_valid_q;
    assign dc_size  = dc_size_q;
    assign dc_value = dc_value_q;
    assign err      = err_q;
endmodule

// File: tb/tb_huffman_dc_decoder.sv
// Scoreboard bench for huffman_dc_decoder: directed streams, expectations queued at issue time.
module tb_huffman_dc_decoder;
    logic              clock = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        jpeg_in;
    logic [3:0]        jpeg_data_bits;
    logic              is_luminance;
    logic              dc_valid;
    logic              dc_ready;
    logic [3:0]        dc_size;
    logic [11:0]       dc_value;
    logic              err;

    typedef struct {
        logic [3:0]         size;
        logic signed [11:0] value;
    } exp_t;

    exp_t               sb[$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic signed [11:0] model_pred = '0;
    logic signed [11:0] hold_val;

    always #5 clock = ~clock;

    huffman_dc_decoder #(.BUF_BITS(32), .OUT_WIDTH(12)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .jpeg_in        (jpeg_in),
        .jpeg_data_bits (jpeg_data_bits),
        .is_luminance   (is_luminance),
        .dc_valid       (dc_valid),
        .dc_ready       (dc_ready),
        .dc_size        (dc_size),
        .dc_value       (dc_value),
        .err            (err)
    );

    function automatic void check(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic logic signed [11:0] push_exp(int size, int diff);
        logic signed [11:0] v;
`ifdef DC_PREDICTOR_EN
        v = model_pred + 12'(diff);
        model_pred = v;
`else
        v = 12'(diff);
`endif
        sb.push_back('{size: 4'(size), value: v});
        return v;
    endfunction

    always @(negedge clock) begin
        if (reset_n && dc_valid && dc_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_symbol: got size %0d value %0d, expected none",
                         dc_size, $signed(dc_value));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dc_size", int'(dc_size), int'(e.size));
                check("dc_value", int'($signed(dc_value)), int'(e.value));
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic [3:0] n);
        int w;
        w = 0;
        jpeg_in        = d;
        jpeg_data_bits = n;
        in_valid       = 1'b1;
        @(negedge clock);
        while (!in_ready && w < 200) begin
            w++;
            @(negedge clock);
        end
        if (w >= 200) check("in_ready_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Upper jpeg_in bits carry leftover stream bits on purpose; the DUT must ignore them.
    task automatic send_stream(input logic [63:0] s, input int n, input int chunk);
        int rem;
        int k;
        logic [63:0] t;
        rem = n;
        while (rem > 0) begin
            k = (rem < chunk) ? rem : chunk;
            t = s >> (rem - k);
            send_beat(t[7:0], 4'(k));
            rem -= k;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clock);
            w++;
        end
        check("drain", sb.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_dc_valid"}, int'(dc_valid), 0);
        check({tag, "_dc_size"}, int'(dc_size), 0);
        check({tag, "_dc_value"}, int'(dc_value), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        jpeg_in        = '0;
        jpeg_data_bits = '0;
        is_luminance   = 1'b1;
        dc_ready       = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset0");
        reset_n = 1'b1;

        // Lum 100 + 101: size 3, +5; dc_valid two clocks after the symbol is queued.
        void'(push_exp(3, 5));
        send_beat(8'b0010_0101, 4'd6);
        check("lat_cycle0", int'(dc_valid), 0);
        @(posedge clock); #1;
        check("lat_cycle1", int'(dc_valid), 0);
        @(posedge clock); #1;
        check("lat_cycle2", int'(dc_valid), 1);
        wait_drain();

        // Lum 011 + 01 split 2,0,2,1: size 2, -2; zero-bit beat is a no-op.
        void'(push_exp(2, -2));
        send_beat(8'b0000_0001, 4'd2);
        send_beat(8'hFF, 4'd0);
        send_beat(8'b0000_0010, 4'd2);
        send_beat(8'b0000_0001, 4'd1);
        wait_drain();

        // Lum 111111110 + eleven zeros: size 11, -2047.
        void'(push_exp(11, -2047));
        send_stream(64'hFF000, 20, 8);
        wait_drain();

        // Backpressure: lum 110+00110 (-25) held while 32 chroma bits queue up.
        dc_ready = 1'b0;
        hold_val = push_exp(5, -25);
        void'(push_exp(1, 1));
        void'(push_exp(1, -1));
        void'(push_exp(3, -5));
        void'(push_exp(4, 9));
        void'(push_exp(5, -16));
        void'(push_exp(0, 0));
        fork
            send_stream(64'hC6_6B2E_9F3C, 40, 8);
            begin
                int w;
                w = 0;
                @(negedge clock);
                while (!dc_valid && w < 50) begin
                    w++;
                    @(negedge clock);
                end
                check("bp_valid_seen", int'(dc_valid), 1);
                for (int unsigned i = 0; i < 10; i++) begin
                    @(negedge clock);
                    check("bp_hold_valid", int'(dc_valid), 1);
                    check("bp_hold_value", int'($signed(dc_value)), int'(hold_val));
                end
                check("bp_in_ready_low", int'(in_ready), 0);
                check("bp_hold_size", int'(dc_size), 5);
            end
        join
        @(posedge clock); #1;
        is_luminance = 1'b0;
        dc_ready     = 1'b1;
        wait_drain();

        // Chroma 00 then 11111111110 + eleven ones: (0,0) then (11,+2047).
        void'(push_exp(0, 0));
        void'(push_exp(11, 2047));
        send_stream(64'h3FF7FF, 24, 8);
        wait_drain();

        // Chroma eleven ones has no code: sticky error, input blocked.
        send_stream(64'h7FF, 11, 8);
        repeat (3) @(posedge clock);
        #1;
        check("err_set", int'(err), 1);
        check("err_in_ready", int'(in_ready), 0);
        check("err_dc_valid", int'(dc_valid), 0);
        in_valid       = 1'b1;
        jpeg_in        = 8'h55;
        jpeg_data_bits = 4'd8;
        repeat (3) @(posedge clock);
        #1;
        check("err_in_ready_held", int'(in_ready), 0);
        check("err_held", int'(err), 1);
        in_valid = 1'b0;

        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n    = 1'b1;
        model_pred = '0;
        check_reset_outputs("reset1");

        // Oversize beat is swallowed and raises err.
        send_beat(8'hAA, 4'd9);
        check("oversize_err", int'(err), 1);
        check("oversize_in_ready", int'(in_ready), 0);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n    = 1'b1;
        model_pred = '0;
        check("reset2_err", int'(err), 0);

        // Recovery: chroma 10 + 11: size 2, +3.
        void'(push_exp(2, 3));
        send_stream(64'hB, 4, 8);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
